mem_lsu: RTL and testbench

Load/store stage of the RV32I core: sits between the ALU stage and the `M_` pipeline latch, turning ALU-stage load/store requests into single-word data-bus transactions. It generates byte strobes and lane-replicated write data for stores, aligns and sign/zero-extends load data, and holds the pipeline via `STALL_OUT` while a bus transaction is outstanding. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_lsu_pkg.sv | 32 +++
 rtl/mem_lsu_align.sv | 58 +++++
 rtl/mem_lsu.sv | 143 ++++++++++++++
 tb/tb_mem_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the RV32I load/store stage.
//   - funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - lsu_state_e: stage FSM state encoding (IDLE=0, REQ=1, WAIT_R=2)
//   - misaligned(): size/alignment test used when MEM_LSU_MISALIGN_TRAP_EN is defined
package mem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsu_state_e;

  // Halfword accesses need a[0]=0, word accesses need a[1:0]=0.
  // Stores only recognise SH as a halfword; loads recognise LH and LHU.
  function automatic logic misaligned(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
    logic half;
    half = is_store ? (f3 == F3_SH) : ((f3 == F3_LH) || (f3 == F3_LHU));
    return (half && a[0]) || ((f3 == F3_LW) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational lane steering for the load/store stage.
//   funct3     in  3   access size/sign
//   addr_lo    in  2   effective address bits [1:0]
//   store_data in  32  rs2 value
//   rdata      in  32  bus read word
//   strb       out 4   write byte enables
//   wdata      out 32  lane-replicated write data
//   load_data  out 32  aligned, extended load result
// Offset bits below the access size are ignored (halfwords use {a[1],0},
// words use 0), so an untrapped misaligned access still hits its own lanes.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] sh;

  always_comb begin
    strb  = '1;
    wdata = store_data;
    case (funct3)
      F3_SB: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        strb  = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh        = rdata;
    load_data = rdata;
    case (funct3)
      F3_LB, F3_LBU: sh = rdata >> {addr_lo, 3'b000};
      F3_LH, F3_LHU: sh = rdata >> {addr_lo[1], 4'b0000};
      default:       sh = rdata;
    endcase
    case (funct3)
      F3_LB:   load_data = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  load_data = {24'h0, sh[7:0]};
      F3_LH:   load_data = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  load_data = {16'h0, sh[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store stage between the ALU stage and the M_ latch.
//   CLK, RST (async, active-low)        clock / reset
//   STALL / STALL_OUT                   downstream hold / upstream hold
//   A_*                                 ALU-stage instruction and operands
//   M_*                                 stage outputs (M_VALID gated to IDLE)
//   MEM_REQ/WE/ADDR/STRB/WDATA/READY    single-word bus request channel
//   MEM_RVALID/RDATA                    read response channel
// Optional: define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of issuing them; this adds the M_MISALIGN output.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  output logic        STALL_OUT,
  input  logic [31:0] A_PC,
  input  logic [31:0] A_INST,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG_D,
  input  logic [31:0] A_REG_D_V,
  input  logic        A_LOAD,
  input  logic        A_STORE,
  input  logic [2:0]  A_FUNCT3,
  input  logic [31:0] A_STORE_DATA,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_VALID,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  ,
  output logic        M_MISALIGN
`endif
);

  lsu_state_e  state;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        valid_r;
  logic [4:0]  rd_r;
  logic [31:0] rdv_r;
  logic        load_r;
  logic        store_r;
  logic [2:0]  f3_r;
  logic [31:0] sdata_r;

  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        is_mem;
  logic        trap;

  assign is_mem = A_VALID && (A_LOAD || A_STORE);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic mis_r;
  assign trap       = is_mem && misaligned(A_STORE, A_FUNCT3, A_REG_D_V[1:0]);
  assign M_MISALIGN = mis_r;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                         mis_r <= 1'b0;
    else if (state == IDLE && !STALL) mis_r <= trap;
  end
`else
  assign trap = 1'b0;
`endif

  mem_lsu_align u_align (
    .funct3     (f3_r),
    .addr_lo    (rdv_r[1:0]),
    .store_data (sdata_r),
    .rdata      (MEM_RDATA),
    .strb       (al_strb),
    .wdata      (al_wdata),
    .load_data  (al_ldata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      pc_r    <= '0;
      inst_r  <= '0;
      valid_r <= 1'b0;
      rd_r    <= '0;
      rdv_r   <= '0;
      load_r  <= 1'b0;
      store_r <= 1'b0;
      f3_r    <= '0;
      sdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!STALL) begin
            pc_r    <= A_PC;
            inst_r  <= A_INST;
            valid_r <= A_VALID;
            rd_r    <= A_REG_D;
            rdv_r   <= A_REG_D_V;
            load_r  <= A_LOAD;
            store_r <= A_STORE;
            f3_r    <= A_FUNCT3;
            sdata_r <= A_STORE_DATA;
            if (is_mem && !trap) state <= REQ;
          end
        end
        REQ: begin
          if (MEM_READY) state <= load_r ? WAIT_R : IDLE;
        end
        WAIT_R: begin
          if (MEM_RVALID) begin
            rdv_r <= al_ldata;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_PC      = pc_r;
    M_INST    = inst_r;
    M_REG_D   = rd_r;
    M_REG_D_V = rdv_r;
    M_VALID   = valid_r && (state == IDLE);
    STALL_OUT = (state != IDLE);
    MEM_REQ   = (state == REQ);
    MEM_WE    = MEM_REQ && store_r;
    MEM_ADDR  = MEM_REQ ? {rdv_r[31:2], 2'b00} : '0;
    MEM_STRB  = MEM_WE ? al_strb : '0;
    MEM_WDATA = MEM_WE ? al_wdata : '0;
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0;
  logic        STALL_OUT;
  logic [31:0] A_PC = '0, A_INST = '0;
  logic        A_VALID = 1'b0;
  logic [4:0]  A_REG_D = '0;
  logic [31:0] A_REG_D_V = '0;
  logic        A_LOAD = 1'b0, A_STORE = 1'b0;
  logic [2:0]  A_FUNCT3 = '0;
  logic [31:0] A_STORE_DATA = '0;
  logic [31:0] M_PC, M_INST, M_REG_D_V;
  logic [4:0]  M_REG_D;
  logic        M_VALID;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_STRB;
  logic        MEM_READY = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic        M_MISALIGN;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_lsu dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .STALL_OUT(STALL_OUT),
    .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID), .A_REG_D(A_REG_D),
    .A_REG_D_V(A_REG_D_V), .A_LOAD(A_LOAD), .A_STORE(A_STORE),
    .A_FUNCT3(A_FUNCT3), .A_STORE_DATA(A_STORE_DATA),
    .M_PC(M_PC), .M_INST(M_INST), .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V),
    .M_VALID(M_VALID), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_STRB(MEM_STRB), .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    , .M_MISALIGN(M_MISALIGN)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: byte-level view of the access rules.
  function automatic int st_bytes(input logic [2:0] f3);
    return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
  endfunction

  function automatic int ld_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input int n, input logic [1:0] a);
    int ai;
    ai = int'(a);
    if (n == 1) return ai;
    if (n == 2) return (ai / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    int n, off;
    n = st_bytes(f3);
    off = lane_off(n, a);
    s = '0;
    for (int k = 0; k < n; k++) s[off + k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = st_bytes(f3);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] r);
    logic [31:0] v, mask;
    int n;
    n = ld_bytes(f3);
    v = r >> (8 * lane_off(n, a));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic bit m_mis(input bit ld, input logic [2:0] f3, input logic [1:0] a);
    bit half;
    half = ld ? (f3 == 3'b001 || f3 == 3'b101) : (f3 == 3'b001);
    return (half && a[0]) || (f3 == 3'b010 && a != 2'b00);
  endfunction

  // One instruction through the stage, with a scripted bus response.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int rdy_wait,
                        input int rv_wait, input bit stall_wait,
                        output logic [31:0] res);
    logic [31:0] pc, inst;
    logic [4:0]  rd;
    bit trap;
    pc = $urandom; inst = $urandom; rd = 5'($urandom);
    trap = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    trap = (ld || st) && m_mis(ld, f3, addr[1:0]);
`endif
    A_PC = pc; A_INST = inst; A_VALID = 1'b1; A_REG_D = rd; A_REG_D_V = addr;
    A_LOAD = ld; A_STORE = st; A_FUNCT3 = f3; A_STORE_DATA = data;
    MEM_READY = (rdy_wait == 0);
    tick();
    if (!(ld || st) || trap) begin
      chk("pass_valid", M_VALID, 1'b1);
      chk("pass_req", MEM_REQ, 1'b0);
      chk("pass_stall_out", STALL_OUT, 1'b0);
      chk("pass_rdv", M_REG_D_V, addr);
    end else begin
      chk("req", MEM_REQ, 1'b1);
      chk("req_addr", MEM_ADDR, {addr[31:2], 2'b00});
      chk("req_we", MEM_WE, st);
      chk("req_strb", MEM_STRB, st ? m_strb(f3, addr[1:0]) : 4'b0000);
      if (st) chk("req_wdata", MEM_WDATA, m_wdata(f3, data));
      chk("req_stall_out", STALL_OUT, 1'b1);
      chk("req_m_valid", M_VALID, 1'b0);
      for (int i = 0; i < rdy_wait; i++) begin
        tick();
        chk("req_hold", MEM_REQ, 1'b1);
        if (i == rdy_wait - 1) MEM_READY = 1'b1;
      end
      tick();
      MEM_READY = 1'b0;
      if (st) begin
        chk("st_done_valid", M_VALID, 1'b1);
        chk("st_done_stall_out", STALL_OUT, 1'b0);
        chk("st_done_req", MEM_REQ, 1'b0);
      end else begin
        STALL = stall_wait;
        MEM_RDATA = ~rdata;
        for (int i = 0; i < rv_wait; i++) begin
          chk("wait_stall_out", STALL_OUT, 1'b1);
          chk("wait_m_valid", M_VALID, 1'b0);
          tick();
        end
        MEM_RVALID = 1'b1;
        MEM_RDATA = rdata;
        tick();
        MEM_RVALID = 1'b0;
        chk("ld_valid", M_VALID, 1'b1);
        chk("ld_stall_out", STALL_OUT, 1'b0);
        chk("ld_data", M_REG_D_V, m_load(f3, addr[1:0], rdata));
      end
    end
    chk("m_pc", M_PC, pc);
    chk("m_inst", M_INST, inst);
    chk("m_rd", {27'h0, M_REG_D}, {27'h0, rd});
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    chk("m_misalign", M_MISALIGN, trap);
`endif
    res = M_REG_D_V;
    A_VALID = 1'b0; A_LOAD = 1'b0; A_STORE = 1'b0;
  endtask

  initial begin
    logic [31:0] res, lw_res;
    int kind;

    // Reset state
    RST = 1'b0;
    repeat (2) tick();
    chk("rst_m_valid", M_VALID, 1'b0);
    chk("rst_stall_out", STALL_OUT, 1'b0);
    chk("rst_req", MEM_REQ, 1'b0);
    chk("rst_rdv", M_REG_D_V, 32'h0);
    chk("rst_pc", M_PC, 32'h0);
    chk("rst_strb", MEM_STRB, 4'h0);
    RST = 1'b1;

    // ALU passthrough
    run_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 1'b0, res);
    chk("add_result", res, 32'h0000_1234);

    // SB to 0x1003, bus ready at once
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, res);

    // LB / LBU from 0x2002, response a few cycles after acceptance
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 2, 1'b0, res);
    chk("lb_value", res, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 2, 1'b0, res);
    chk("lbu_value", res, 32'h0000_0080);

    // LW with slow acceptance and STALL during WAIT_R
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 4, 1, 1'b1, lw_res);
    chk("lw_value", lw_res, 32'hCAFE_F00D);
    A_VALID = 1'b1; A_REG_D_V = 32'h0000_55AA; A_LOAD = 1'b0; A_STORE = 1'b0;
    tick();
    tick();
    chk("stall_hold_valid", M_VALID, 1'b1);
    chk("stall_hold_rdv", M_REG_D_V, 32'hCAFE_F00D);
    STALL = 1'b0;
    tick();
    chk("stall_release_rdv", M_REG_D_V, 32'h0000_55AA);
    chk("stall_release_valid", M_VALID, 1'b1);
    A_VALID = 1'b0;

    // LH at 0x3001
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 32'h1234_8765, 0, 0, 1'b0, res);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    chk("lh_mis_rdv", res, 32'h0000_3001);
`else
    chk("lh_mis_value", res, 32'hFFFF_8765);
`endif

    // Reset during WAIT_R, then a late response
    A_VALID = 1'b1; A_LOAD = 1'b1; A_FUNCT3 = 3'b010; A_REG_D_V = 32'h0000_5000;
    A_PC = 32'h0000_0ABC;
    MEM_READY = 1'b1;
    tick();
    tick();
    MEM_READY = 1'b0;
    chk("pre_rst_stall_out", STALL_OUT, 1'b1);
    A_VALID = 1'b0; A_LOAD = 1'b0; A_REG_D_V = '0; A_PC = '0;
    RST = 1'b0;
    #1;
    chk("mid_rst_stall_out", STALL_OUT, 1'b0);
    chk("mid_rst_req", MEM_REQ, 1'b0);
    chk("mid_rst_rdv", M_REG_D_V, 32'h0);
    chk("mid_rst_pc", M_PC, 32'h0);
    tick();
    RST = 1'b1;
    MEM_RVALID = 1'b1;
    MEM_RDATA = 32'hDEAD_BEEF;
    tick();
    MEM_RVALID = 1'b0;
    chk("late_rvalid_rdv", M_REG_D_V, 32'h0);
    chk("late_rvalid_valid", M_VALID, 1'b0);
    chk("late_rvalid_stall_out", STALL_OUT, 1'b0);

    // Randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      run_op(kind == 1, kind == 2, 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
